bus_uart_tx: RTL

Memory-mapped UART transmitter that sits on the core's data bus as a responder, opposite the core's load/store initiator port. The core writes bytes into an 8-entry FIFO, and a baud-rate serializer drives them out as 8N1 frames on `tx`. Reads return data combinationally, in the same cycle, as the single-cycle core requires. Writes take effect on the clock edge.

---
 rtl/bus_uart_pkg.sv | 23 ++
 rtl/bus_uart_tx_sync_fifo.sv | 48 ++++
 rtl/bus_uart_tx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and serializer states.
package bus_uart_pkg;

    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_DIV    = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_CNT   = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

endpackage

// File: rtl/bus_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = count == CW'(DEPTH);
    assign empty    = count == '0;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register decode, TX FIFO
// and baud-rate serializer.
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic        bus_write,
    input  logic        bus_read,
    output logic [31:0] bus_read_data,
    output logic        hit,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   div;
    logic          irq_en;
    logic          overflow;
    tx_state_t     state;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [15:0]   baud_cnt;
    logic [15:0]   bit_len;
    logic [3:0]    reg_off;
    logic          wr_en;
    logic          push;
    logic          busy;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;
    logic          bus_unused;

    assign hit     = bus_address[31:4] == BASE_ADDR[31:4];
    assign reg_off = {bus_address[3:2], 2'b00};
    assign wr_en   = hit && bus_write;
    assign push    = wr_en && (reg_off == REG_DATA);
    assign busy    = state != S_IDLE;
    assign bit_len = (div == 16'd0) ? 16'd0 : div - 16'd1;

    assign bus_unused = ^{bus_address[1:0], bus_write_data[31:16]};

    // Pop on leaving IDLE, or at the end of a stop bit for back-to-back frames.
    assign fifo_pop = !fifo_empty &&
        ((state == S_IDLE) || (state == S_STOP && baud_cnt == 16'd0));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (bus_write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        status               = '0;
        status[ST_FULL]      = fifo_full;
        status[ST_EMPTY]     = fifo_empty;
        status[ST_BUSY]      = busy;
        status[ST_OVF]       = overflow;
        status[ST_CNT +: 4]  = 4'(fifo_count);
    end

    always_comb begin
        bus_read_data = '0;
        if (hit && bus_read) begin
            unique case (reg_off)
                REG_DATA:   bus_read_data = '0;
                REG_STATUS: bus_read_data = status;
                REG_DIV:    bus_read_data = {16'h0, div};
                REG_CTRL:   bus_read_data = {31'h0, irq_en};
                default:    bus_read_data = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div      <= DEFAULT_DIV;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= irq_en && fifo_empty && !busy;
            if (push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (wr_en && reg_off == REG_STATUS && bus_write_data[ST_OVF])
                overflow <= 1'b0;
            if (wr_en && reg_off == REG_DIV)
                div <= bus_write_data[15:0];
            if (wr_en && reg_off == REG_CTRL)
                irq_en <= bus_write_data[0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        shift    <= fifo_head;
                        baud_cnt <= bit_len;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else begin
                        bit_idx  <= '0;
                        baud_cnt <= bit_len;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else begin
                        baud_cnt <= bit_len;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
                S_STOP: begin
                    if (baud_cnt != 16'd0) begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end else if (fifo_pop) begin
                        shift    <= fifo_head;
                        baud_cnt <= bit_len;
                        tx       <= 1'b0;
                        state    <= S_START;
                    end else begin
                        tx    <= 1'b1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
